// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between two req/ack masters.
// Each access is a fixed IDLE -> ACCESS -> DONE sequence; out-of-range accesses return an error instead of reaching memory.
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic                     m0_be,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_ack,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    output logic                     m0_err,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic                     m1_be,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    output logic                     m1_ack,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic                     m1_err,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_we,
    output logic                     mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

    logic [1:0]               state;
    logic                     last_grant;
    logic                     sel_port;
    logic                     sel_we;
    logic                     sel_err;

    logic                     grant;
    logic                     gnt_we;
    logic                     gnt_be;
    logic                     gnt_oor;
    logic [ADDRESS_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0]    gnt_wdata;

    // On a tie the port that did not win last time is served; a lone request wins outright.
    always_comb begin
        grant     = (m0_req && m1_req) ? ~last_grant : m1_req;
        gnt_we    = grant ? m1_we    : m0_we;
        gnt_be    = grant ? m1_be    : m0_be;
        gnt_addr  = grant ? m1_addr  : m0_addr;
        gnt_wdata = grant ? m1_wdata : m0_wdata;
        gnt_oor   = ({1'b0, gnt_addr} >= LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            sel_port       <= 1'b0;
            sel_we         <= 1'b0;
            sel_err        <= 1'b0;
            m0_ack         <= 1'b0;
            m0_err         <= 1'b0;
            m0_rdata       <= '0;
            m1_ack         <= 1'b0;
            m1_err         <= 1'b0;
            m1_rdata       <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_we         <= 1'b0;
            mem_be         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        sel_port       <= grant;
                        sel_we         <= gnt_we;
                        sel_err        <= gnt_oor;
                        mem_address    <= gnt_addr;
                        mem_write_data <= gnt_wdata;
                        mem_be         <= gnt_be;
                        mem_we         <= gnt_we && !gnt_oor;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we     <= 1'b0;
                    last_grant <= sel_port;
                    if (sel_port) begin
                        m1_ack <= 1'b1;
                        m1_err <= sel_err;
                        if (sel_err)     m1_rdata <= '0;
                        else if (!sel_we) m1_rdata <= mem_read_data;
                    end else begin
                        m0_ack <= 1'b1;
                        m0_err <= sel_err;
                        if (sel_err)     m0_rdata <= '0;
                        else if (!sel_we) m0_rdata <= mem_read_data;
                    end
                    state <= DONE;
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_ack <= 1'b0;
                    m1_err <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed memory model plus a transaction-level reference of arbitration and data.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MS = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_v [2];
    logic          we_v  [2];
    logic          be_v  [2];
    logic [AW-1:0] addr_v[2];
    logic [DW-1:0] wd_v  [2];

    logic          m0_ack, m1_ack, m0_err, m1_err, mem_we, mem_be;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_write_data, mem_read_data;
    logic [AW-1:0] mem_address;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req_v[0]), .m0_we(we_v[0]), .m0_be(be_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wd_v[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(req_v[1]), .m1_we(we_v[1]), .m1_be(be_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wd_v[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_we(mem_we), .mem_be(mem_be),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory: word array, byte lanes little-endian, byte reads zero-extended.
    logic [31:0] emem [MS/4];
    always_comb begin
        mem_read_data = 32'hBAD0BAD0;
        if (mem_address < MS) begin
            mem_read_data = emem[int'(mem_address >> 2)];
            if (mem_be) mem_read_data = {24'h0, mem_read_data[8*mem_address[1:0] +: 8]};
        end
    end
    always @(posedge clk) begin
        if (mem_we && mem_address < MS) begin
            if (mem_be) emem[int'(mem_address >> 2)][8*mem_address[1:0] +: 8] <= mem_write_data[7:0];
            else        emem[int'(mem_address >> 2)] <= mem_write_data;
        end
    end

    int cyc = 0;
    int we_cnt = 0;
    always @(posedge clk) begin
        cyc++;
        if (mem_we) we_cnt++;
    end

    // Reference model state
    logic [7:0]    ref_b [MS];
    logic          last_g;
    logic [DW-1:0] exp_rd [2];
    int            we_mark;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic we, input logic be,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        we_v[p] = we; be_v[p] = be; addr_v[p] = addr; wd_v[p] = wd; req_v[p] = 1'b1;
    endtask

    task automatic model_reset();
        last_g = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Applies port p's transaction to the model; returns expected err and expected write-strobe cycles.
    task automatic model_apply(input int p, output logic e_err, output int e_we);
        int a;
        e_err = (addr_v[p] >= MS);
        e_we  = 0;
        if (e_err) begin
            exp_rd[p] = '0;
        end else begin
            a = int'(addr_v[p]);
            if (we_v[p]) begin
                e_we = 1;
                if (be_v[p]) ref_b[a] = wd_v[p][7:0];
                else for (int i = 0; i < 4; i++) ref_b[(a & ~3) + i] = wd_v[p][8*i +: 8];
            end else if (be_v[p]) begin
                exp_rd[p] = {24'h0, ref_b[a]};
            end else begin
                a = a & ~3;
                exp_rd[p] = {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
            end
        end
    endtask

    // Serves n acks; caller sets requests at a negedge while the arbiter is idle.
    task automatic serve(input int n, input bit hold);
        int   waited;
        int   last_cyc;
        int   p;
        logic e_err;
        int   e_we;
        last_cyc = 0;
        we_mark  = we_cnt;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (!(m0_ack || m1_ack) && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            if (!(m0_ack || m1_ack)) begin
                check_eq("ack_timeout", 1'b0, 1'b1);
                req_v[0] = 1'b0; req_v[1] = 1'b0;
                return;
            end
            p = (req_v[0] && req_v[1]) ? int'(!last_g) : int'(req_v[1]);
            check_eq("one_ack", m0_ack && m1_ack, 1'b0);
            check_eq("winner", m1_ack, p[0]);
            if (k == 0) check_eq("latency", waited, 2);
            else        check_eq("spacing", cyc - last_cyc, 3);
            last_cyc = cyc;
            last_g = p[0];
            model_apply(p, e_err, e_we);
            check_eq("rdata_win", p ? m1_rdata : m0_rdata, exp_rd[p]);
            check_eq("err_win",   p ? m1_err : m0_err, e_err);
            check_eq("rdata_oth", p ? m0_rdata : m1_rdata, exp_rd[1-p]);
            check_eq("err_oth",   p ? m0_err : m1_err, 1'b0);
            check_eq("we_cycles", we_cnt - we_mark, e_we);
            we_mark = we_cnt;
            if (!hold) req_v[p] = 1'b0;
            else if (k == n - 1) begin req_v[0] = 1'b0; req_v[1] = 1'b0; end
            @(negedge clk);
            check_eq("ack_width", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ctl", {m0_ack, m1_ack, m0_err, m1_err, mem_we, mem_be}, 6'b0);
        check_eq("rst_m0_rdata", m0_rdata, 0);
        check_eq("rst_m1_rdata", m1_rdata, 0);
        check_eq("rst_mem_addr", mem_address, 0);
        check_eq("rst_mem_wdata", mem_write_data, 0);
    endtask

    initial begin
        logic [31:0] w;
        int          mism;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; be_v[p] = 1'b0; addr_v[p] = '0; wd_v[p] = '0;
        end
        for (int i = 0; i < MS/4; i++) begin
            w = $urandom;
            emem[i] = w;
            for (int b = 0; b < 4; b++) ref_b[4*i + b] = w[8*b +: 8];
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        @(negedge clk);

        // Port 0 word write then read back
        set_port(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF); serve(1, 0);
        set_port(0, 1'b0, 1'b0, 32'h10, 32'h0);        serve(1, 0);
        check_eq("m0_word_rd", m0_rdata, 32'hDEADBEEF);

        // Port 1 byte write then read back
        set_port(1, 1'b1, 1'b1, 32'h11, 32'hFFFFFFA5); serve(1, 0);
        set_port(1, 1'b0, 1'b1, 32'h11, 32'h0);        serve(1, 0);
        check_eq("m1_byte_rd", m1_rdata, 32'h000000A5);
        check_eq("m0_kept", m0_rdata, 32'hDEADBEEF);

        // Both held: alternating service
        set_port(0, 1'b0, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b0, 1'b1, 32'h11, 32'h0);
        serve(4, 1);

        // Out-of-range read and write at MEM_SIZE
        set_port(0, 1'b0, 1'b0, MS, 32'h0);        serve(1, 0);
        check_eq("oor_rdata", m0_rdata, 0);
        set_port(0, 1'b1, 1'b0, MS, 32'hCAFEF00D); serve(1, 0);

        // Reset during a port 1 write access
        set_port(1, 1'b1, 1'b0, 32'h40, 32'h12345678);
        @(posedge clk); #1;
        check_eq("rst_pre_we", mem_we, 1'b1);
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        req_v[1] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h40, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h10, 32'h0);
        serve(2, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int pat;
            pat = $urandom_range(3, 1);
            for (int p = 0; p < 2; p++) begin
                if (pat[p]) set_port(p, 1'($urandom), 1'($urandom),
                                     ($urandom_range(7, 0) == 0) ? MS + $urandom_range(255, 0)
                                                                 : $urandom_range(MS - 1, 0),
                                     $urandom);
            end
            serve(pat[0] + pat[1], 0);
        end

        mism = 0;
        for (int i = 0; i < MS/4; i++)
            if (emem[i] !== {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]}) mism++;
        check_eq("mem_image", mism, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter sharing the single-ported data memory between the processor load/store path (port 0) and a second master (port 1, e.g. loader or peripheral DMA). Each port runs a req/ack handshake; the arbiter serialises accesses, drives the memory's address/write_data/we/be inputs, captures combinational read data into a per-port register, and flags out-of-range accesses instead of forwarding them.

## Interface
- DATA_WIDTH, 32, data word width
- ADDRESS_WIDTH, 32, address width
- MEM_SIZE, 1024, range limit; address >= MEM_SIZE is an error access
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  access request, held until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_be / m1_be  in  1  1 = byte access (sbp/lbp), 0 = word
- m0_addr / m1_addr  in  ADDRESS_WIDTH  byte address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data (byte in [7:0] when be)
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_WIDTH  registered read data, valid with ack, held until next ack to that port
- m0_err / m1_err  out  1  high with ack when access was out of range
- mem_address  out  ADDRESS_WIDTH  to memory address
- mem_write_data  out  DATA_WIDTH  to memory write_data
- mem_we  out  1  to memory we
- mem_be  out  1  to memory be
- mem_read_data  in  DATA_WIDTH  combinational memory read data

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: if any req high, select winner, latch its we/be/addr/wdata and port id, go ACCESS; else stay.
- Arbitration: single request wins outright; both high -> port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
- ACCESS (one cycle): mem_address/mem_be driven from latched request. mem_we = latched we AND in-range; memory write occurs at end of this cycle. For reads, mem_read_data captured into winner's rdata register at end of cycle. Update last_grant. Go DONE.
- Out of range (addr >= MEM_SIZE): mem_we held 0, rdata register loaded 0, err flag set for the pulse.
- DONE: winner's ack = 1 (and err if flagged); go IDLE. Writes leave rdata unchanged.
- Requests sampled only in IDLE. A req still high in the IDLE cycle after ack is a new transaction.
- Requester dropping req during ACCESS/DONE does not abort; transaction completes and ack is still pulsed.
- Non-granted port's req is ignored until next IDLE; it wins the following arbitration if still high.

## Timing
- Reset (async assert): state IDLE, last_grant 1, all outputs 0 (acks, errs, rdata, mem_address, mem_write_data, mem_we, mem_be). Reset mid-ACCESS aborts with no write issued after reset asserts.
- Latency: req high at edge N (IDLE) -> ACCESS cycle N..N+1 -> ack high cycle N+1..N+2. Three cycles per transaction; max one ack per 3 cycles.
- mem_we high only during ACCESS; 0 in IDLE and DONE (memory sees reads otherwise).
- mem_address, mem_be, mem_write_data are registered; stable for whole ACCESS cycle; hold last value in IDLE/DONE.
- Only one ack asserted in any cycle; ack width exactly one cycle.

## Test plan
- Port 0 word write addr 0x10 data 0xDEADBEEF, then word read 0x10 -> mem_we high one cycle, second ack with m0_rdata = 0xDEADBEEF, err 0.
- Port 1 byte write addr 0x11 data 0xA5, then byte read 0x11 -> m1_rdata = 0x000000A5; m0 outputs unchanged.
- Both req high at same edge, held continuously for 4 transactions -> ack order m0, m1, m0, m1; each ack 3 cycles apart.
- Port 0 read addr MEM_SIZE -> mem_we stays 0, m0_ack with m0_err = 1, m0_rdata = 0; write to same address leaves memory unchanged.
- Assert rst during ACCESS of a port 1 write -> all outputs 0 immediately, no write landed, next request after release completes normally with port 0 winning a tie.
